crc8_frame_checker: RTL

Receive-side counterpart of the team's CRC-8 LFSR generators. It accepts a byte stream framed by start-of-frame and end-of-frame markers and recomputes the CRC-8 bit-serially, one bit per clock, using the same MSB-first LFSR as the generator. It compares the result with the trailing CRC byte the transmitter appended. It sits after the byte deserializer and reports one pass/fail verdict per frame, plus the frame's data length.

---
 rtl/crc8_frame_checker.sv | 114 +++++++++++
 1 files changed

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: recomputes an MSB-first CRC-8 bit-serially
// over each framed byte stream and compares it against the trailing CRC byte.
module crc8_frame_checker #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic        clock,
  input  logic        reset_b,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic        in_ready,
  output logic [7:0]  crc_value,
  output logic [15:0] frame_len,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, FRAME, REPORT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  crc;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [15:0] byte_cnt;
  logic        accept;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  endfunction

  assign accept    = in_valid && in_ready;
  assign crc_value = crc;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE, FRAME: begin
        in_ready = 1'b1;
        if (accept) begin
          if (in_sof && in_eof)      state_nxt = REPORT;
          else if (in_sof)           state_nxt = SHIFT;
          else if (state == FRAME)   state_nxt = in_eof ? REPORT : SHIFT;
        end
      end
      SHIFT:  if (bit_cnt == 3'd0) state_nxt = FRAME;
      REPORT: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Verdict and length are registered on the CRC-byte edge so they are valid
  // in the same cycle as the done pulse.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      crc       <= INIT;
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      frame_len <= '0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, FRAME: begin
          if (accept) begin
            if (in_sof && in_eof) begin
              crc       <= INIT;
              byte_cnt  <= '0;
              frame_len <= '0;
              crc_ok    <= (in_data == INIT);
              crc_err   <= (in_data != INIT);
            end else if (in_sof) begin
              crc      <= INIT;
              byte_cnt <= 16'd1;
              crc_ok   <= 1'b0;
              crc_err  <= 1'b0;
              shreg    <= in_data;
              bit_cnt  <= 3'd7;
            end else if (state == FRAME && in_eof) begin
              frame_len <= byte_cnt;
              crc_ok    <= (in_data == crc);
              crc_err   <= (in_data != crc);
            end else if (state == FRAME) begin
              if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
              shreg   <= in_data;
              bit_cnt <= 3'd7;
            end
          end
        end
        SHIFT: begin
          crc     <= crc_step(crc, shreg[bit_cnt]);
          bit_cnt <= bit_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
